// File: rtl/keypad_pkg.sv
// Shared types and key-value constants for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN  = 2'd0,
        DEB_P = 2'd1,
        PRESS = 2'd2,
        DEB_R = 2'd3
    } kp_state_e;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'b1010;
    localparam logic [3:0] KEY_HASH = 4'b1100;
    localparam logic [3:0] KEY_NONE = 4'b0000;

endpackage

// File: rtl/keypad_map.sv
// Key index (row*4 + col of the 4x4 layout) to key value; column 3 and
// indexes outside the 4x4 grid map to zero.
module keypad_map
    import keypad_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic [IDX_W-1:0] idx_i,
    output logic [3:0]       val_o
);

    always_comb begin
        val_o = KEY_NONE;
        case (32'(idx_i))
            0:       val_o = KEY_1;
            1:       val_o = KEY_2;
            2:       val_o = KEY_3;
            4:       val_o = KEY_4;
            5:       val_o = KEY_5;
            6:       val_o = KEY_6;
            8:       val_o = KEY_7;
            9:       val_o = KEY_8;
            10:      val_o = KEY_9;
            12:      val_o = KEY_STAR;
            13:      val_o = KEY_0;
            14:      val_o = KEY_HASH;
            default: val_o = KEY_NONE;
        endcase
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: one-hot row drive, synchronised column sampling once
// per row dwell, press/release debounce, optional auto-repeat.
module keypad_scan_ctrl
    import keypad_pkg::*;
#(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 4,
    parameter  int DEBOUNCE   = 3,
    parameter  int REPEAT_DLY = 0,
    localparam int CODE_W     = $clog2(ROWS*COLS)
) (
    input  logic              clk_Teclado,
    input  logic              rst_n,
    input  logic [COLS-1:0]   Columna,
    output logic [ROWS-1:0]   Fila,
    output logic [CODE_W-1:0] key_code,
    output logic [3:0]        key_val,
    output logic              key_valid,
    output logic              key_release,
    output logic              key_held,
    output logic              key_multi,
    output kp_state_e         dbg_state_o
);

    localparam int DIV_W  = $clog2(SCAN_DIV);
    localparam int CNT_W  = $clog2(DEBOUNCE+1);
    localparam int REP_W  = $clog2(REPEAT_DLY+2);
    localparam int RIDX_W = $clog2(ROWS);
    localparam int CIDX_W = $clog2(COLS);

    logic [COLS-1:0]   sync1_q, col_s_q;
    logic [DIV_W-1:0]  div_q;
    kp_state_e         state_q;
    logic [ROWS-1:0]   fila_q;
    logic [RIDX_W-1:0] row_q;
    logic [COLS-1:0]   col_q;
    logic [CIDX_W-1:0] col_idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [REP_W-1:0]  rep_q;
    logic [CODE_W-1:0] code_q;
    logic [3:0]        val_q;
    logic              valid_q, rel_q, held_q, multi_q;

    logic              tick;
    logic              col_match;
    logic [CIDX_W-1:0] enc;
    logic [CIDX_W-1:0] sel_idx;
    logic [CODE_W-1:0] press_code;
    logic [3:0]        press_val;
    logic [REP_W-1:0]  rep_nxt;

    assign tick      = (div_q == DIV_W'(SCAN_DIV-1));
    assign col_match = (col_s_q == col_q);
    assign rep_nxt   = rep_q + 1'b1;

    always_comb begin
        enc = '0;
        for (int i = 0; i < COLS; i++) begin
            if (col_s_q[i]) enc = CIDX_W'(i);
        end
    end

    // In SCAN the column is being latched this tick, so use the live encoding.
    assign sel_idx    = (state_q == SCAN) ? enc : col_idx_q;
    assign press_code = CODE_W'(row_q) * CODE_W'(COLS) + CODE_W'(sel_idx);

    keypad_map #(.IDX_W(CODE_W)) u_map (
        .idx_i (press_code),
        .val_o (press_val)
    );

    always_ff @(posedge clk_Teclado or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            col_s_q <= '0;
            div_q   <= '0;
        end else begin
            sync1_q <= Columna;
            col_s_q <= sync1_q;
            div_q   <= tick ? '0 : div_q + 1'b1;
        end
    end

    always_ff @(posedge clk_Teclado or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SCAN;
            fila_q    <= ROWS'(1);
            row_q     <= '0;
            col_q     <= '0;
            col_idx_q <= '0;
            cnt_q     <= '0;
            rep_q     <= '0;
            code_q    <= '0;
            val_q     <= '0;
            valid_q   <= 1'b0;
            rel_q     <= 1'b0;
            held_q    <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            rel_q   <= 1'b0;
            multi_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    SCAN: begin
                        if ($onehot(col_s_q)) begin
                            col_q     <= col_s_q;
                            col_idx_q <= enc;
                            cnt_q     <= CNT_W'(1);
                            rep_q     <= '0;
                            if (DEBOUNCE == 1) begin
                                state_q <= PRESS;
                                valid_q <= 1'b1;
                                held_q  <= 1'b1;
                                code_q  <= press_code;
                                val_q   <= press_val;
                            end else begin
                                state_q <= DEB_P;
                            end
                        end else begin
                            multi_q <= (col_s_q != '0);
                            fila_q  <= {fila_q[ROWS-2:0], fila_q[ROWS-1]};
                            row_q   <= (row_q == RIDX_W'(ROWS-1)) ? '0 : row_q + 1'b1;
                        end
                    end
                    DEB_P: begin
                        if (col_match) begin
                            if (cnt_q == CNT_W'(DEBOUNCE-1)) begin
                                state_q <= PRESS;
                                cnt_q   <= '0;
                                rep_q   <= '0;
                                valid_q <= 1'b1;
                                held_q  <= 1'b1;
                                code_q  <= press_code;
                                val_q   <= press_val;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end else begin
                            state_q <= SCAN;
                            cnt_q   <= '0;
                            fila_q  <= {fila_q[ROWS-2:0], fila_q[ROWS-1]};
                            row_q   <= (row_q == RIDX_W'(ROWS-1)) ? '0 : row_q + 1'b1;
                        end
                    end
                    PRESS: begin
                        if (col_match) begin
                            if (REPEAT_DLY > 0) begin
                                if (rep_nxt == REP_W'(REPEAT_DLY)) begin
                                    valid_q <= 1'b1;
                                    rep_q   <= '0;
                                end else begin
                                    rep_q <= rep_nxt;
                                end
                            end
                        end else if (DEBOUNCE == 1) begin
                            state_q <= SCAN;
                            rel_q   <= 1'b1;
                            held_q  <= 1'b0;
                            fila_q  <= {fila_q[ROWS-2:0], fila_q[ROWS-1]};
                            row_q   <= (row_q == RIDX_W'(ROWS-1)) ? '0 : row_q + 1'b1;
                        end else begin
                            state_q <= DEB_R;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    DEB_R: begin
                        // A matching sample means the release was a bounce; rep_q is kept.
                        if (col_match) begin
                            state_q <= PRESS;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_W'(DEBOUNCE-1)) begin
                            state_q <= SCAN;
                            cnt_q   <= '0;
                            rel_q   <= 1'b1;
                            held_q  <= 1'b0;
                            fila_q  <= {fila_q[ROWS-2:0], fila_q[ROWS-1]};
                            row_q   <= (row_q == RIDX_W'(ROWS-1)) ? '0 : row_q + 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: state_q <= SCAN;
                endcase
            end
        end
    end

    assign Fila        = fila_q;
    assign key_code    = code_q;
    assign key_val     = val_q;
    assign key_valid   = valid_q;
    assign key_release = rel_q;
    assign key_held    = held_q;
    assign key_multi   = multi_q;
    assign dbg_state_o = state_q;

endmodule
